// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared state codes and stall encodings for the pipeline
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_LOAD_BUBBLE = 2'd1,
        ST_FLUSH_PEND  = 2'd2,
        ST_FLUSH_DONE  = 2'd3
    } state_t;

    // stall vector bits: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
    localparam logic [5:0] STALL_NONE    = 6'b000000;
    localparam logic [5:0] STALL_IF      = 6'b000011;
    localparam logic [5:0] STALL_LOADUSE = 6'b000111;
    localparam logic [5:0] STALL_MEM     = 6'b011111;

    localparam logic [9:0] WDOG_LIMIT = 10'd1023;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard check between EX and ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       i_ex_is_load,
    input  logic [4:0] i_ex_wd,
    input  logic       i_id_reg1_read,
    input  logic [4:0] i_id_reg1_addr,
    input  logic       i_id_reg2_read,
    input  logic [4:0] i_id_reg2_addr,
    output logic       o_load_use
);

    logic w_reg1_hit;
    logic w_reg2_hit;

    assign w_reg1_hit = i_id_reg1_read && (i_id_reg1_addr == i_ex_wd);
    assign w_reg2_hit = i_id_reg2_read && (i_id_reg2_addr == i_ex_wd);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign o_load_use = i_ex_is_load && (i_ex_wd != 5'd0) && (w_reg1_hit || w_reg2_hit);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard controller: stalls, branch flush, load-use
//               bubble, performance counters and memory-stall watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall_req,
    input  logic        mem_stall_req,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_wd,
    input  logic        id_reg1_read,
    input  logic        id_reg2_read,
    input  logic [4:0]  id_reg1_addr,
    input  logic [4:0]  id_reg2_addr,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    output logic [5:0]  stall_o,
    output logic        last_load_o,
    output logic        flush_o,
    output logic [31:0] redirect_pc_o,
    output logic        hang_o,
    output logic [31:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_target;
    logic        r_br_block;
    logic [31:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic [9:0]  r_wdog;
    logic        r_hang;

    logic        w_load_use;
    logic        w_branch;
    logic [5:0]  w_stall;
    logic        w_flush;
    logic [31:0] w_redir;
    logic        w_latch;

    hazard_detect u_hazard_detect (
        .i_ex_is_load   (ex_is_load),
        .i_ex_wd        (ex_wd),
        .i_id_reg1_read (id_reg1_read),
        .i_id_reg1_addr (id_reg1_addr),
        .i_id_reg2_read (id_reg2_read),
        .i_id_reg2_addr (id_reg2_addr),
        .o_load_use     (w_load_use)
    );

    // A branch held in EX across several cycles is one branch: after its
    // flush, further taken cycles are masked until the request drops.
    assign w_branch = ex_branch_taken && !r_br_block;

    always_comb begin
        w_next  = r_state;
        w_stall = STALL_NONE;
        w_flush = 1'b0;
        w_redir = 32'd0;
        w_latch = 1'b0;
        case (r_state)
            ST_RUN, ST_LOAD_BUBBLE: begin
                w_next = ST_RUN;
                if (mem_stall_req) begin
                    w_stall = STALL_MEM;
                    if (w_branch) begin
                        w_latch = 1'b1;
                        w_next  = ST_FLUSH_PEND;
                    end
                end else if (w_branch) begin
                    w_flush = 1'b1;
                    w_redir = ex_branch_target;
                    w_next  = ST_FLUSH_DONE;
                end else if (w_load_use) begin
                    w_stall = STALL_LOADUSE;
                    w_next  = ST_LOAD_BUBBLE;
                end else if (if_stall_req) begin
                    w_stall = STALL_IF;
                end
            end
            ST_FLUSH_PEND: begin
                if (mem_stall_req) begin
                    w_stall = STALL_MEM;
                end else begin
                    w_flush = 1'b1;
                    w_redir = r_target;
                    w_next  = ST_FLUSH_DONE;
                end
            end
            ST_FLUSH_DONE: begin
                // ID was just flushed, so any load-use match here is stale
                w_next = ST_RUN;
                if (mem_stall_req) begin
                    w_stall = STALL_MEM;
                end else if (if_stall_req) begin
                    w_stall = STALL_IF;
                end
            end
            default: begin
                w_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_target   <= 32'd0;
            r_br_block <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_target <= ex_branch_target;
            end
            if (w_flush) begin
                r_br_block <= 1'b1;
            end else if (!ex_branch_taken) begin
                r_br_block <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if ((w_stall != STALL_NONE) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    // hang sets on the same edge the consecutive-stall count reaches the limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog <= 10'd0;
            r_hang <= 1'b0;
        end else begin
            if (mem_stall_req) begin
                if (r_wdog != WDOG_LIMIT) begin
                    r_wdog <= r_wdog + 10'd1;
                end
                if (r_wdog == (WDOG_LIMIT - 10'd1)) begin
                    r_hang <= 1'b1;
                end
            end else begin
                r_wdog <= 10'd0;
            end
        end
    end

    // Combinational outputs are gated so reset silences them immediately
    assign stall_o       = rst ? w_stall : STALL_NONE;
    assign flush_o       = rst && w_flush;
    assign redirect_pc_o = rst ? w_redir : 32'd0;
    assign last_load_o   = rst && (r_state == ST_LOAD_BUBBLE);
    assign hang_o        = r_hang;
    assign stall_cnt_o   = r_stall_cnt;
    assign flush_cnt_o   = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed, table-driven self-checking bench for pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        if_stall_req;
    logic        mem_stall_req;
    logic        ex_is_load;
    logic [4:0]  ex_wd;
    logic        id_reg1_read;
    logic        id_reg2_read;
    logic [4:0]  id_reg1_addr;
    logic [4:0]  id_reg2_addr;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic [5:0]  stall_o;
    logic        last_load_o;
    logic        flush_o;
    logic [31:0] redirect_pc_o;
    logic        hang_o;
    logic [31:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    pipe_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .if_stall_req     (if_stall_req),
        .mem_stall_req    (mem_stall_req),
        .ex_is_load       (ex_is_load),
        .ex_wd            (ex_wd),
        .id_reg1_read     (id_reg1_read),
        .id_reg2_read     (id_reg2_read),
        .id_reg1_addr     (id_reg1_addr),
        .id_reg2_addr     (id_reg2_addr),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .stall_o          (stall_o),
        .last_load_o      (last_load_o),
        .flush_o          (flush_o),
        .redirect_pc_o    (redirect_pc_o),
        .hang_o           (hang_o),
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        mem;
        logic        ifs;
        logic        ld;
        logic [4:0]  wd;
        logic        r1rd;
        logic [4:0]  r1a;
        logic        r2rd;
        logic [4:0]  r2a;
        logic        br;
        logic [31:0] tgt;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_redir;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_stall_req     = 1'b0;
        mem_stall_req    = 1'b0;
        ex_is_load       = 1'b0;
        ex_wd            = 5'd0;
        id_reg1_read     = 1'b0;
        id_reg2_read     = 1'b0;
        id_reg1_addr     = 5'd0;
        id_reg2_addr     = 5'd0;
        ex_branch_taken  = 1'b0;
        ex_branch_target = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        mem_stall_req    = v.mem;
        if_stall_req     = v.ifs;
        ex_is_load       = v.ld;
        ex_wd            = v.wd;
        id_reg1_read     = v.r1rd;
        id_reg1_addr     = v.r1a;
        id_reg2_read     = v.r2rd;
        id_reg2_addr     = v.r2a;
        ex_branch_taken  = v.br;
        ex_branch_target = v.tgt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state with busy inputs: outputs must still be quiet
        idle_inputs();
        rst = 1'b0;
        mem_stall_req    = 1'b1;
        ex_branch_taken  = 1'b1;
        ex_branch_target = 32'h1234_5678;
        #1;
        chk("rst_stall", {26'd0, stall_o}, 32'h0);
        chk("rst_flush", {31'd0, flush_o}, 32'h0);
        chk("rst_redir", redirect_pc_o, 32'h0);
        chk("rst_last_load", {31'd0, last_load_o}, 32'h0);
        chk("rst_hang", {31'd0, hang_o}, 32'h0);
        chk("rst_stall_cnt", stall_cnt_o, 32'h0);
        chk("rst_flush_cnt", {16'd0, flush_cnt_o}, 32'h0);

        //          mem   ifs   ld    wd     r1rd  r1a    r2rd  r2a    br    tgt            stall      flush redir
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 32'h0,         6'b000000, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 32'h0,         6'b000011, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 32'h0,         6'b011111, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 32'h300,       6'b011111, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 32'h100,       6'b000000, 1'b1, 32'h100};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 5'd5,  1'b0, 32'h0,         6'b000111, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  1'b0, 32'h0,         6'b000000, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 5'd5,  1'b0, 5'd5,  1'b0, 32'h0,         6'b000011, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 5'd9,  1'b1, 5'd9,  1'b0, 5'd0,  1'b0, 32'h0,         6'b000111, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 5'd3,  1'b1, 5'd3,  1'b0, 5'd0,  1'b1, 32'hCAFE_0000, 6'b000000, 1'b1, 32'hCAFE_0000};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 5'd4,  1'b1, 5'd4,  1'b1, 5'd4,  1'b0, 32'h0,         6'b011111, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 5'd6,  1'b1, 5'd6,  1'b1, 5'd6,  1'b0, 32'h0,         6'b000000, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 5'd31, 1'b1, 5'd30, 1'b1, 5'd31, 1'b0, 32'h0,         6'b000111, 1'b0, 32'h0};

        for (int i = 0; i < 13; i++) begin
            do_reset();
            apply(vecs[i]);
            #1;
            chk($sformatf("vec%0d_stall", i), {26'd0, stall_o}, {26'd0, vecs[i].e_stall});
            chk($sformatf("vec%0d_flush", i), {31'd0, flush_o}, {31'd0, vecs[i].e_flush});
            chk($sformatf("vec%0d_redir", i), redirect_pc_o, vecs[i].e_redir);
            chk($sformatf("vec%0d_last_load", i), {31'd0, last_load_o}, 32'h0);
        end

        // load-use: one stall cycle, then a one-cycle bubble indicator
        do_reset();
        ex_is_load = 1'b1; ex_wd = 5'd5; id_reg2_read = 1'b1; id_reg2_addr = 5'd5;
        #1;
        chk("lu_stall", {26'd0, stall_o}, 32'h07);
        chk("lu_last0", {31'd0, last_load_o}, 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("lu_last1", {31'd0, last_load_o}, 32'h1);
        chk("lu_stall1", {26'd0, stall_o}, 32'h0);
        @(negedge clk);
        #1;
        chk("lu_last2", {31'd0, last_load_o}, 32'h0);
        chk("lu_stall2", {26'd0, stall_o}, 32'h0);
        chk("lu_stall_cnt", stall_cnt_o, 32'd1);

        // load into x0 never stalls
        do_reset();
        ex_is_load = 1'b1; id_reg1_read = 1'b1; id_reg2_read = 1'b1;
        #1;
        chk("x0_stall", {26'd0, stall_o}, 32'h0);
        @(negedge clk);
        #1;
        chk("x0_last", {31'd0, last_load_o}, 32'h0);
        chk("x0_stall_cnt", stall_cnt_o, 32'd0);

        // branch held for three cycles: exactly one flush
        do_reset();
        ex_branch_taken = 1'b1; ex_branch_target = 32'h100;
        #1;
        chk("br_flush0", {31'd0, flush_o}, 32'h1);
        chk("br_redir0", redirect_pc_o, 32'h100);
        @(negedge clk);
        #1;
        chk("br_flush1", {31'd0, flush_o}, 32'h0);
        chk("br_redir1", redirect_pc_o, 32'h0);
        @(negedge clk);
        #1;
        chk("br_flush2", {31'd0, flush_o}, 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("br_flush3", {31'd0, flush_o}, 32'h0);
        @(negedge clk);
        #1;
        chk("br_flush_cnt", {16'd0, flush_cnt_o}, 32'd1);

        // branch during a four-cycle memory stall: target latched, flush afterwards
        do_reset();
        mem_stall_req = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h200;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("pend_stall%0d", k), {26'd0, stall_o}, 32'h1F);
            chk($sformatf("pend_flush%0d", k), {31'd0, flush_o}, 32'h0);
            @(negedge clk);
            if (k == 0) ex_branch_target = 32'h999;
        end
        mem_stall_req = 1'b0;
        #1;
        chk("pend_flush", {31'd0, flush_o}, 32'h1);
        chk("pend_redir", redirect_pc_o, 32'h200);
        chk("pend_stall_end", {26'd0, stall_o}, 32'h0);
        @(negedge clk);
        #1;
        chk("pend_flush_after", {31'd0, flush_o}, 32'h0);
        @(negedge clk);
        ex_branch_taken = 1'b0;
        #1;
        chk("pend_flush_blocked", {31'd0, flush_o}, 32'h0);
        chk("pend_stall_cnt", stall_cnt_o, 32'd4);
        chk("pend_flush_cnt", {16'd0, flush_cnt_o}, 32'd1);

        // watchdog: 1023 consecutive memory-stall cycles
        do_reset();
        mem_stall_req = 1'b1;
        repeat (1022) @(negedge clk);
        #1;
        chk("wd_hang_1022", {31'd0, hang_o}, 32'h0);
        @(negedge clk);
        mem_stall_req = 1'b0;
        #1;
        chk("wd_hang_1023", {31'd0, hang_o}, 32'h1);
        repeat (3) @(negedge clk);
        #1;
        chk("wd_hang_sticky", {31'd0, hang_o}, 32'h1);
        chk("wd_stall_cnt", stall_cnt_o, 32'd1023);
        rst = 1'b0;
        #1;
        chk("wd_hang_rst", {31'd0, hang_o}, 32'h0);

        // reset during FLUSH_PEND discards the pending redirect
        do_reset();
        mem_stall_req = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h400;
        @(negedge clk);
        #1;
        chk("rp_stall", {26'd0, stall_o}, 32'h1F);
        rst = 1'b0;
        #1;
        chk("rp_stall_rst", {26'd0, stall_o}, 32'h0);
        chk("rp_flush_rst", {31'd0, flush_o}, 32'h0);
        chk("rp_redir_rst", redirect_pc_o, 32'h0);
        mem_stall_req = 1'b0; ex_branch_taken = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("rp_flush%0d", k), {31'd0, flush_o}, 32'h0);
            chk($sformatf("rp_stall%0d", k), {26'd0, stall_o}, 32'h0);
            @(negedge clk);
        end
        #1;
        chk("rp_flush_cnt", {16'd0, flush_cnt_o}, 32'd0);
        chk("rp_redir_end", redirect_pc_o, 32'h0);

        // reset during LOAD_BUBBLE drops the bubble indicator
        do_reset();
        ex_is_load = 1'b1; ex_wd = 5'd12; id_reg1_read = 1'b1; id_reg1_addr = 5'd12;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rb_last", {31'd0, last_load_o}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rb_last_rst", {31'd0, last_load_o}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rb_last_after", {31'd0, last_load_o}, 32'h0);
        chk("rb_stall_after", {26'd0, stall_o}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have clk  in  1  pipeline clock, rising-edge active.
REQ-002 SHALL have rst  in  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have if_stall_req  in  1  fetch waiting on instruction memory.
REQ-004 SHALL have mem_stall_req  in  1  memory stage busy with a multi-cycle access.
REQ-005 SHALL have ex_is_load  in  1  instruction in EX is a load.
REQ-006 SHALL have ex_wd  in  5  destination register of the EX instruction.
REQ-007 SHALL have id_reg1_read, id_reg2_read  in  1 each  ID source-read enables.
REQ-008 SHALL have id_reg1_addr, id_reg2_addr  in  5 each  ID source register addresses.
REQ-009 SHALL have ex_branch_taken  in  1, ex_branch_target  in  32  redirect request and target from EX.
REQ-010 SHALL have stall_o  out  6  per-stage hold: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
REQ-011 SHALL have last_load_o  out  1  load-use bubble indicator to ID.
REQ-012 SHALL have flush_o  out  1, redirect_pc_o  out  32  one-cycle IF/ID and ID/EX flush plus new PC.
REQ-013 SHALL have hang_o  out  1  sticky memory-stall watchdog flag.
REQ-014 SHALL have stall_cnt_o  out  32, flush_cnt_o  out  16  performance counters.

Function
REQ-015 States SHALL be RUN, LOAD_BUBBLE, FLUSH_PEND, FLUSH_DONE; state registered, stall_o/flush_o combinational from state and inputs.
REQ-016 Load-use hazard SHALL be ex_is_load & ex_wd!=0 & ((id_reg1_read & id_reg1_addr==ex_wd) | (id_reg2_read & id_reg2_addr==ex_wd)).
REQ-017 Priority per cycle SHALL be mem_stall_req > branch > load-use > if_stall_req.
REQ-018 mem_stall_req=1 SHALL give stall_o=6'b011111, flush_o=0.
REQ-019 In RUN, ex_branch_taken with mem_stall_req=0 SHALL give flush_o=1, redirect_pc_o=ex_branch_target, stall_o=0, next state FLUSH_DONE.
REQ-020 In RUN, ex_branch_taken with mem_stall_req=1 SHALL latch the target and move to FLUSH_PEND; the flush pulse SHALL be issued in the first cycle mem_stall_req=0, with the latched target, then go to FLUSH_DONE.
REQ-021 FLUSH_DONE SHALL last exactly one cycle, ignore ex_branch_taken (same branch still visible), return to RUN; exactly one flush pulse per branch.
REQ-022 Load-use (no higher-priority event) SHALL give stall_o=6'b000111 in the detection cycle, next state LOAD_BUBBLE.
REQ-023 LOAD_BUBBLE SHALL drive last_load_o=1 for exactly one cycle, apply REQ-017 rules normally, then return to RUN; last_load_o=0 in all other states.
REQ-024 if_stall_req alone SHALL give stall_o=6'b000011; no request SHALL give stall_o=0.
REQ-025 redirect_pc_o SHALL be 0 whenever flush_o=0.
REQ-026 stall_cnt_o SHALL increment by 1 each cycle stall_o!=0, saturating at 32'hFFFFFFFF.
REQ-027 flush_cnt_o SHALL increment by 1 per flush pulse, wrapping 16'hFFFF->0.
REQ-028 A 10-bit watchdog SHALL count consecutive mem_stall_req=1 cycles, clear when it drops, and set hang_o when it reaches 1023; hang_o stays 1 until reset.

Reset
REQ-029 rst=0 SHALL immediately force state RUN, stall_o=0, flush_o=0, redirect_pc_o=0, last_load_o=0, hang_o=0, counters and watchdog 0, latched target 0.
REQ-030 Reset asserted mid-FLUSH_PEND or LOAD_BUBBLE SHALL discard the pending action; no flush issued after release.

Structure
REQ-031 Stall encodings (STALL_MEM, STALL_LOADUSE, STALL_IF, STALL_NONE) and state codes SHALL live in the shared defines.v.
REQ-032 Load-use comparison SHALL be a combinational sub-module hazard_detect; FSM, counters and watchdog stay in pipe_ctrl.

Verification
REQ-033 EX load ex_wd=5, ID reads x5 on reg2 -> stall_o=000111 one cycle, last_load_o=1 next cycle, then stall_o=0.
REQ-034 EX load ex_wd=0, ID reads x0 -> no stall, last_load_o stays 0.
REQ-035 ex_branch_taken=1 target 0x100 held 3 cycles, no mem stall -> single flush_o pulse with redirect_pc_o=0x100, flush_cnt_o=1.
REQ-036 ex_branch_taken=1 target 0x200 during 4-cycle mem_stall_req -> stall_o=011111 x4, then one flush with 0x200; stall_cnt_o=4.
REQ-037 mem_stall_req high 1023 cycles -> hang_o=1 on cycle 1023 and remains 1 after mem_stall_req drops, until rst=0.
REQ-038 rst=0 during FLUSH_PEND, release with mem_stall_req=0 -> flush_o never pulses, all outputs 0.
